// File: rtl/qci_stream_filter.sv
// rtl/qci_stream_filter.sv - 802.1Qci per-frame stream gate and max-SDU filter with one output register slice
// Optional statistics counters are built when QCI_STATS_EN is defined.
module qci_stream_filter #(
  parameter int DATA_W   = 64,
  parameter int KEEP_W   = 8,
  parameter int LEN_W    = 11,
  parameter int ID_W     = 12,
  parameter int GATE_NUM = 128,
  parameter int CNT_W    = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [DATA_W-1:0]   rx_axis_tdata,
  input  logic [KEEP_W-1:0]   rx_axis_tkeep,
  input  logic                rx_axis_tlast,
  input  logic                rx_axis_tvalid,
  output logic                rx_axis_tready,
  input  logic [LEN_W-1:0]    frame_len_in,
  input  logic [LEN_W-1:0]    max_frame_len_in,
  input  logic [ID_W-1:0]     gate_id_in,
  input  logic [ID_W-1:0]     meter_id_in,
  input  logic [GATE_NUM-1:0] gate_state_in,
  output logic [DATA_W-1:0]   tx_axis_tdata,
  output logic [KEEP_W-1:0]   tx_axis_tkeep,
  output logic                tx_axis_tlast,
  output logic                tx_axis_tvalid,
  input  logic                tx_axis_tready,
  output logic                tx_sof,
  output logic [LEN_W-1:0]    frame_len_out,
  output logic [ID_W-1:0]     meter_id_out,
  output logic [CNT_W-1:0]    cnt_pass,
  output logic [CNT_W-1:0]    cnt_drop_oversize,
  output logic [CNT_W-1:0]    cnt_drop_gate
);

  localparam int GIDX_W = (GATE_NUM > 1) ? $clog2(GATE_NUM) : 1;

  typedef enum logic [1:0] {IDLE, PASS, DROP} state_t;
  state_t state;

  logic accept, sof, oversize, gate_in_range, gate_bad, pass_sof, fwd;

  assign rx_axis_tready = !tx_axis_tvalid || tx_axis_tready;
  assign accept         = rx_axis_tvalid && rx_axis_tready;
  assign sof            = accept && (state == IDLE);

  assign oversize      = (max_frame_len_in != '0) && (frame_len_in > max_frame_len_in);
  // Range check first so an out-of-range id never indexes past the gate vector.
  assign gate_in_range = (32'(gate_id_in) < 32'(GATE_NUM));
  assign gate_bad      = !gate_in_range || !gate_state_in[gate_id_in[GIDX_W-1:0]];
  assign pass_sof      = sof && !oversize && !gate_bad;
  assign fwd           = pass_sof || (accept && (state == PASS));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= IDLE;
      tx_axis_tdata  <= '0;
      tx_axis_tkeep  <= '0;
      tx_axis_tlast  <= 1'b0;
      tx_axis_tvalid <= 1'b0;
      tx_sof         <= 1'b0;
      frame_len_out  <= '0;
      meter_id_out   <= '0;
    end else begin
      if (accept) begin
        case (state)
          IDLE:    if (!rx_axis_tlast) state <= pass_sof ? PASS : DROP;
          default: if (rx_axis_tlast) state <= IDLE;
        endcase
      end
      // The slice only reloads when empty or draining, which keeps stalled data stable.
      if (rx_axis_tready) begin
        tx_axis_tvalid <= fwd;
        tx_sof         <= pass_sof;
        if (fwd) begin
          tx_axis_tdata <= rx_axis_tdata;
          tx_axis_tkeep <= rx_axis_tkeep;
          tx_axis_tlast <= rx_axis_tlast;
        end
      end
      if (pass_sof) begin
        frame_len_out <= frame_len_in;
        meter_id_out  <= meter_id_in;
      end
    end
  end

`ifdef QCI_STATS_EN
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_pass          <= '0;
      cnt_drop_oversize <= '0;
      cnt_drop_gate     <= '0;
    end else if (sof) begin
      if (oversize)      cnt_drop_oversize <= sat_inc(cnt_drop_oversize);
      else if (gate_bad) cnt_drop_gate     <= sat_inc(cnt_drop_gate);
      else               cnt_pass          <= sat_inc(cnt_pass);
    end
  end
`else
  assign cnt_pass          = '0;
  assign cnt_drop_oversize = '0;
  assign cnt_drop_gate     = '0;
`endif

endmodule

// File: tb/tb_qci_stream_filter.sv
// tb/tb_qci_stream_filter.sv - self-checking bench for qci_stream_filter against a frame-level model
module tb_qci_stream_filter;
  localparam int DATA_W = 64, KEEP_W = 8, LEN_W = 11, ID_W = 12, GATE_NUM = 128, CNT_W = 32;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic [DATA_W-1:0]   rx_axis_tdata = '0;
  logic [KEEP_W-1:0]   rx_axis_tkeep = '0;
  logic                rx_axis_tlast = 1'b0;
  logic                rx_axis_tvalid = 1'b0;
  logic                rx_axis_tready;
  logic [LEN_W-1:0]    frame_len_in = '0;
  logic [LEN_W-1:0]    max_frame_len_in = '0;
  logic [ID_W-1:0]     gate_id_in = '0;
  logic [ID_W-1:0]     meter_id_in = '0;
  logic [GATE_NUM-1:0] gate_state_in = '1;
  logic [DATA_W-1:0]   tx_axis_tdata;
  logic [KEEP_W-1:0]   tx_axis_tkeep;
  logic                tx_axis_tlast;
  logic                tx_axis_tvalid;
  logic                tx_axis_tready = 1'b1;
  logic                tx_sof;
  logic [LEN_W-1:0]    frame_len_out;
  logic [ID_W-1:0]     meter_id_out;
  logic [CNT_W-1:0]    cnt_pass, cnt_drop_oversize, cnt_drop_gate;

  qci_stream_filter #(
    .DATA_W(DATA_W), .KEEP_W(KEEP_W), .LEN_W(LEN_W), .ID_W(ID_W), .GATE_NUM(GATE_NUM), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst),
    .rx_axis_tdata(rx_axis_tdata), .rx_axis_tkeep(rx_axis_tkeep), .rx_axis_tlast(rx_axis_tlast),
    .rx_axis_tvalid(rx_axis_tvalid), .rx_axis_tready(rx_axis_tready),
    .frame_len_in(frame_len_in), .max_frame_len_in(max_frame_len_in),
    .gate_id_in(gate_id_in), .meter_id_in(meter_id_in), .gate_state_in(gate_state_in),
    .tx_axis_tdata(tx_axis_tdata), .tx_axis_tkeep(tx_axis_tkeep), .tx_axis_tlast(tx_axis_tlast),
    .tx_axis_tvalid(tx_axis_tvalid), .tx_axis_tready(tx_axis_tready), .tx_sof(tx_sof),
    .frame_len_out(frame_len_out), .meter_id_out(meter_id_out),
    .cnt_pass(cnt_pass), .cnt_drop_oversize(cnt_drop_oversize), .cnt_drop_gate(cnt_drop_gate)
  );

  typedef struct {
    logic [63:0] d;
    logic [7:0]  k;
    logic        l;
    logic        s;
    logic [10:0] len;
    logic [11:0] mid;
  } beat_t;

  beat_t exp_q[$];
  int checks = 0, passes = 0, cyc = 0, out_beats = 0, retries = 0;
  int m_pass = 0, m_over = 0, m_gate = 0;
  int rdy_mode = 0, sof_acc_cyc = 0, sof_out_cyc = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act === req) passes++;
    else $display("FAIL %s: actual=%0h required=%0h", name, act, req);
  endtask

  function automatic int ec(input int v);
`ifdef QCI_STATS_EN
    return v;
`else
    return (v < 0) ? v : 0;
`endif
  endfunction

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial forever begin
    @(negedge clk);
    case (rdy_mode)
      0:       tx_axis_tready = 1'b1;
      1:       tx_axis_tready = ~tx_axis_tready;
      default: tx_axis_tready = ($urandom_range(0, 3) != 0);
    endcase
  end

  // Output compare process: every cycle, away from the clock edge.
  initial begin
    logic [127:0] held, cur;
    bit stalled;
    beat_t e;
    stalled = 0;
    held = '0;
    forever begin
      @(negedge clk);
      #2;
      if (!rst) stalled = 0;
      else begin
        cur = {31'd0, tx_axis_tdata, tx_axis_tkeep, tx_axis_tlast, tx_sof, frame_len_out, meter_id_out};
        chk("rx_tready_rule", rx_axis_tready, !tx_axis_tvalid || tx_axis_tready);
        if (stalled) chk("stall_hold", {tx_axis_tvalid, cur[96:0]}, {1'b1, held[96:0]});
        if (tx_axis_tvalid && tx_axis_tready) begin
          out_beats++;
          if (exp_q.size() == 0) chk("spurious_beat", 1, 0);
          else begin
            e = exp_q.pop_front();
            chk("out_beat", cur, {31'd0, e.d, e.k, e.l, e.s, e.len, e.mid});
            if (e.s) sof_out_cyc = cyc;
          end
        end
        stalled = tx_axis_tvalid && !tx_axis_tready;
        held = cur;
      end
    end
  end

  task automatic do_reset();
    rx_axis_tvalid = 1'b0;
    rst = 1'b0;
    #1;
    chk("rst_outputs", {tx_axis_tvalid, tx_sof, tx_axis_tlast, tx_axis_tdata, tx_axis_tkeep,
                        frame_len_out, meter_id_out}, '0);
    chk("rst_tready", rx_axis_tready, 1);
    chk("rst_counters", {cnt_pass, cnt_drop_oversize, cnt_drop_gate}, '0);
    exp_q.delete();
    m_pass = 0; m_over = 0; m_gate = 0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  // Drives one frame; the model decides at SOF from the sampled inputs and queues expected output.
  task automatic send_frame(input int len, input int maxl, input int gid, input int mid,
                            input int gap, input int flip_at, input int rst_at);
    int nb, rem;
    bit pass, acc;
    logic [63:0] d;
    logic [7:0] lastk;
    beat_t b;
    nb = (len + 7) / 8;
    if (nb == 0) nb = 1;
    rem = len % 8;
    lastk = (rem == 0) ? 8'hff : 8'((1 << rem) - 1);
    pass = 0;
    for (int i = 0; i < nb; i++) begin
      if (i == rst_at) begin
        do_reset();
        return;
      end
      if (i == flip_at) gate_state_in = ~gate_state_in;
      while (gap > 0 && $urandom_range(0, gap) == 0) begin
        rx_axis_tvalid = 1'b0;
        @(negedge clk);
      end
      d = {$urandom(), $urandom()};
      rx_axis_tdata = d;
      rx_axis_tkeep = (i == nb - 1) ? lastk : 8'hff;
      rx_axis_tlast = (i == nb - 1);
      if (i == 0) begin
        frame_len_in = LEN_W'(len);
        max_frame_len_in = LEN_W'(maxl);
        gate_id_in = ID_W'(gid);
        meter_id_in = ID_W'(mid);
      end else begin
        frame_len_in = LEN_W'($urandom());
        max_frame_len_in = LEN_W'($urandom());
        gate_id_in = ID_W'($urandom());
        meter_id_in = ID_W'($urandom());
      end
      rx_axis_tvalid = 1'b1;
      acc = 0;
      for (int t = 0; t < 100 && !acc; t++) begin
        #1;
        if (rx_axis_tready) acc = 1;
        else begin
          retries++;
          @(negedge clk);
        end
      end
      if (!acc) begin
        chk("accept_timeout", 0, 1);
        rx_axis_tvalid = 1'b0;
        return;
      end
      if (i == 0) begin
        if (maxl != 0 && len > maxl) m_over++;
        else if (gid >= GATE_NUM) m_gate++;
        else if (!gate_state_in[gid]) m_gate++;
        else begin
          m_pass++;
          pass = 1;
          sof_acc_cyc = cyc;
        end
      end
      if (pass) begin
        b.d = d; b.k = rx_axis_tkeep; b.l = rx_axis_tlast; b.s = (i == 0);
        b.len = LEN_W'(len); b.mid = ID_W'(mid);
        exp_q.push_back(b);
      end
      @(negedge clk);
    end
    rx_axis_tvalid = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    rx_axis_tvalid = 1'b0;
    while (exp_q.size() != 0 && t < 400) begin
      @(negedge clk);
      t++;
    end
    if (exp_q.size() != 0) chk("drain_timeout", exp_q.size(), 0);
    repeat (3) @(negedge clk);
  endtask

  task automatic chk_counters(input string tag);
    chk({tag, "_cnt_pass"}, cnt_pass, ec(m_pass));
    chk({tag, "_cnt_over"}, cnt_drop_oversize, ec(m_over));
    chk({tag, "_cnt_gate"}, cnt_drop_gate, ec(m_gate));
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int ob, r, len, maxl;
    @(negedge clk);
    #1;
    chk("init_tready", rx_axis_tready, 1);
    chk("init_outputs", {tx_axis_tvalid, tx_sof, frame_len_out, meter_id_out}, '0);
    chk("init_counters", {cnt_pass, cnt_drop_oversize, cnt_drop_gate}, '0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // 1: passing 8-beat frame
    rdy_mode = 0;
    ob = out_beats;
    send_frame(64, 1000, 3, 5, 0, -1, -1);
    drain();
    chk("t1_beats", out_beats - ob, 8);
    chk("t1_latency", sof_out_cyc - sof_acc_cyc, 1);
    chk("t1_frame_len_out", frame_len_out, 64);
    chk("t1_meter_id_out", meter_id_out, 5);
    chk("t1_cnt_pass", cnt_pass, ec(1));

    // 2: oversize drop, no backpressure on the input
    ob = out_beats; r = retries;
    send_frame(1500, 1000, 3, 6, 0, -1, -1);
    drain();
    chk("t2_beats", out_beats - ob, 0);
    chk("t2_no_stall", retries - r, 0);
    chk("t2_cnt_over", cnt_drop_oversize, ec(1));
    chk("t2_meter_held", meter_id_out, 5);

    // 3: max=0 means no limit
    ob = out_beats;
    send_frame(1500, 0, 3, 7, 0, -1, -1);
    drain();
    chk("t3_beats", out_beats - ob, 188);
    chk("t3_cnt_pass", cnt_pass, ec(2));

    // 4: closed gate, invalid gate, gate opened mid-frame
    gate_state_in[7] = 1'b0;
    ob = out_beats;
    send_frame(100, 0, 7, 1, 0, -1, -1);
    drain();
    chk("t4a_cnt_gate", cnt_drop_gate, ec(1));
    send_frame(100, 0, 200, 1, 0, -1, -1);
    drain();
    chk("t4b_cnt_gate", cnt_drop_gate, ec(2));
    send_frame(64, 0, 7, 2, 0, 3, -1);
    drain();
    chk("t4c_cnt_gate", cnt_drop_gate, ec(3));
    chk("t4_beats", out_beats - ob, 0);

    // 5: 1010 backpressure, then back-to-back single-beat frames with boundary decisions
    gate_state_in = '1;
    rdy_mode = 1;
    ob = out_beats;
    send_frame(80, 0, 1, 9, 0, -1, -1);
    drain();
    chk("t5_beats", out_beats - ob, 10);
    gate_state_in[7] = 1'b0;
    send_frame(8, 8, 2, 11, 0, -1, -1);
    send_frame(8, 7, 2, 12, 0, -1, -1);
    send_frame(5, 4, 200, 13, 0, -1, -1);
    send_frame(3, 0, 7, 14, 0, -1, -1);
    send_frame(1, 0, 127, 15, 0, -1, -1);
    send_frame(8, 0, 128, 16, 0, -1, -1);
    drain();
    chk_counters("t5");

    // randomized frames, gaps and backpressure
    rdy_mode = 2;
    for (int f = 0; f < 40; f++) begin
      len = $urandom_range(1, 120);
      case ($urandom_range(0, 2))
        0:       maxl = 0;
        1:       maxl = $urandom_range(1, 120);
        default: maxl = len;
      endcase
      gate_state_in = {$urandom(), $urandom(), $urandom(), $urandom()};
      send_frame(len, maxl, $urandom_range(0, 140), $urandom_range(0, 4095), 3,
                 $urandom_range(1, 16), -1);
    end
    drain();
    chk_counters("rand");

    // 6: reset in the middle of a frame
    rdy_mode = 0;
    gate_state_in = '1;
    send_frame(64, 0, 3, 4, 0, -1, 3);
    @(negedge clk);
    #1;
    chk("t6_counters_after", {cnt_pass, cnt_drop_oversize, cnt_drop_gate}, '0);
    chk("t6_tvalid_after", tx_axis_tvalid, 0);
    @(negedge clk);
    ob = out_beats;
    send_frame(16, 0, 3, 21, 0, -1, -1);
    drain();
    chk("t6_beats", out_beats - ob, 2);
    chk("t6_meter_id_out", meter_id_out, 21);
    chk("t6_cnt_pass", cnt_pass, ec(1));

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
